wb_serial_mc: RTL
=================

Name: wb_serial_mc

Overview:
- Wishbone slave that controls NCH single-wire humidity/temperature sensor engines, one per channel; each engine runs the DHT-style bit protocol on its own wire.
- Adds over the single-channel slave: per-channel trigger mask, autonomous periodic sampling, round-robin scheduling, checksum validation, timeout detection, sticky status/error flags and an interrupt.
- Sits on the SoC Wishbone bus beside the other wb_* peripherals; the engines are instantiated one level up and connect through meas_o/done_i/raw_i.

Parameters:
- NCH, 4, number of sensor channels (1..8)
- TIMEOUT, 32'd5_000_000, clocks allowed between meas_o pulse and done_i before a timeout error
- PERIOD_RST, 32'd0, PERIOD register reset value (0 = auto sampling off)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wb_adr_i  in  32  byte address; only [6:2] decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  registered read data
- wb_sel_i  in  4  ignored; full-word access only
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_ack_o  out  1  acknowledge
- irq_o  out  1  level interrupt
- meas_o  out  NCH  one-cycle start pulse per channel engine
- done_i  in  NCH  one-cycle completion pulse per engine
- raw_i  in  40*NCH  per channel {hum,humd,tem,temd,sum}; valid in the done_i cycle

Behaviour:
- Reset: clk is the only clock; reset is asynchronous, active-high. Reset clears ack, wb_dat_o, irq_o, meas_o, all flags, pending, counters and data registers to 0, sets PERIOD=PERIOD_RST and puts the FSM in IDLE. A reset mid-measurement abandons it; a late done_i is ignored because the FSM is in IDLE.
- Bus handshake: ack registers to 1 one cycle after stb&cyc&~ack and drops the following cycle, so every access takes 2 cycles. wb_ack_o = stb & cyc & ack. wb_dat_o loads in the same cycle as ack.
- Unmapped reads return 0. Writes to read-only or unmapped registers are acked and ignored.
- Register map (word offset):
  - 0x00 CTRL (RW): [0] auto_en, [1] irq_en, [15:8] chan_en mask.
  - 0x04 STATUS (RO): [0] busy (FSM != IDLE), [6:4] cur_ch, [15:8] pending.
  - 0x08 PERIOD (RW, 32 bit).
  - 0x0C TRIG (WO): written [NCH-1:0] ORed into pending.
  - 0x10 DONE (W1C): sticky per-channel valid-sample flags [NCH-1:0].
  - 0x14 CKERR (W1C): checksum-error flags.
  - 0x18 TOERR (W1C): timeout-error flags.
  - 0x40+8*ch DATA0 (RO): {hum,humd,tem,temd}.
  - 0x44+8*ch DATA1 (RO): {16'b0, sum, 8-bit wrapping good-sample count}.
  - Channels >= NCH read 0.
- Period timer: runs only while auto_en=1 and PERIOD!=0. Counts 0..PERIOD-1; at the terminal count it ORs chan_en into pending and wraps to 0. Clearing auto_en or writing PERIOD zeroes the counter.
- Pending: multiple sets of the same bit merge into one request. If a set (TRIG write or timer) and the FSM clear of the same bit land in the same cycle, the set wins.
- FSM states and transitions:
  - IDLE: if pending != 0, pick the next set bit searching round-robin from last_ch+1 (wrap at NCH); cur_ch <= it; go START.
  - START: meas_o[cur_ch]=1 for exactly one cycle; load timeout counter with TIMEOUT; go WAIT.
  - WAIT: if done_i[cur_ch], capture raw_i slice and go CHECK. Else, when the counter reaches 0, set TOERR[cur_ch], clear pending[cur_ch], last_ch<=cur_ch and go IDLE. done_i on other channels is ignored.
  - CHECK: compute (hum+humd+tem+temd) mod 256.
    - Equal to sum: update DATA0/DATA1, increment count (wraps 255->0), set DONE[cur_ch].
    - Not equal: set CKERR[cur_ch]; data registers are unchanged.
    - Either case: clear pending[cur_ch], last_ch<=cur_ch, go IDLE.
- W1C vs hardware set: a write-1-to-clear in the same cycle as a hardware set of the same flag leaves the flag set.
- irq_o: registered irq_en & |(DONE|CKERR|TOERR).
- Minimum per-channel turnaround is 3 cycles plus engine latency.

Decomposition:
- Package wb_serial_mc_pkg: register offset localparams, FSM state encoding (IDLE, START, WAIT, CHECK), CTRL bit indices.
- One natural sub-module: wb_serial_rr_arb (NCH-wide round-robin picker: pending + last_ch -> next index, any flag).
- Everything else stays flat in wb_serial_mc.

Test Plan:
- Register reset/readback: after reset, PERIOD reads PERIOD_RST and CTRL reads 0. Write CTRL=0x0F03 -> reads 0x0F03. Every access acks exactly 1 cycle after stb.
- Single trigger, good checksum: TRIG=0x2; engine 1 returns {0x37,0x00,0x19,0x00,0x50} -> meas_o[1] pulses once; DATA0[1]=0x37001900, DATA1[1]=0x5001, DONE=0x2, irq_o=1 when irq_en.
- Bad checksum: sum=0x51 -> CKERR=0x2, DATA0 unchanged, count unchanged. W1C 0x2 -> CKERR=0, irq_o drops.
- Timeout: TIMEOUT=100 build, no done_i -> TOERR[0] set exactly 101 cycles after meas_o; busy=0 afterwards.
- Auto round-robin: chan_en=0xF, PERIOD=1000, auto_en=1 -> meas_o order 0,1,2,3 each period. TRIG for a pending channel adds no extra measurement.
- Async reset asserted in WAIT -> meas_o, busy and pending are 0 immediately; a later done_i causes no DONE flag.

Source files
------------

// File: rtl/wb_serial_mc_pkg.sv
// Shared definitions for the multi-channel serial humidity/temperature sensor controller.
package wb_serial_mc_pkg;

  localparam int unsigned MaxCh = 8;

  // Word indices (byte address [6:2]); index bit 4 selects the per-channel data window.
  localparam logic [4:0] AdrCtrl   = 5'h00;
  localparam logic [4:0] AdrStatus = 5'h01;
  localparam logic [4:0] AdrPeriod = 5'h02;
  localparam logic [4:0] AdrTrig   = 5'h03;
  localparam logic [4:0] AdrDone   = 5'h04;
  localparam logic [4:0] AdrCkerr  = 5'h05;
  localparam logic [4:0] AdrToerr  = 5'h06;

  localparam int unsigned CtrlAutoEn  = 0;
  localparam int unsigned CtrlIrqEn   = 1;
  localparam int unsigned CtrlChanLsb = 8;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StCheck} state_e;

  // Byte-wise checksum of {hum, humd, tem, temd}, wrapping mod 256.
  function automatic logic [7:0] dht_sum(input logic [31:0] d);
    return d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/wb_serial_rr_arb.sv
// Round-robin picker: finds the next pending channel after last_ch, wrapping at NCH.
module wb_serial_rr_arb #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0] pending,
  input  logic [2:0]     last_ch,
  output logic [2:0]     next_ch,
  output logic           any
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    next_ch = last_ch;
    for (int i = NCH; i >= 1; i--) begin
      for (int c = 0; c < NCH; c++) begin
        if (((int'(last_ch) + i) % NCH) == c && pending[c]) begin
          next_ch = 3'(c);
        end
      end
    end
  end

  assign any = |pending;

endmodule

// File: rtl/wb_serial_mc.sv
// Wishbone slave scheduling NCH single-wire sensor engines with checksum/timeout checking.
module wb_serial_mc
  import wb_serial_mc_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned TIMEOUT    = 32'd5_000_000,
  parameter logic [31:0] PERIOD_RST = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  output logic              wb_ack_o,
  output logic              irq_o,
  output logic [NCH-1:0]    meas_o,
  input  logic [NCH-1:0]    done_i,
  input  logic [40*NCH-1:0] raw_i
);

  logic        ack_q, irq_q, auto_en_q, irq_en_q;
  logic [31:0] dat_q, rd_data, period_q, tick_cnt_q, tmo_q;
  logic [7:0]  chan_en_q;
  logic [2:0]  cur_ch_q, last_ch_q, arb_next, rd_ch;
  logic [39:0] raw_q, raw_sel;
  logic [31:0] data0_q [MaxCh];
  logic [7:0]  sum_q   [MaxCh];
  logic [7:0]  cnt_q   [MaxCh];
  logic [NCH-1:0] pend_q, done_q, ckerr_q, toerr_q, cur_mask, pend_set, pend_clr;
  logic [NCH-1:0] done_w1c, ckerr_w1c, toerr_w1c;
  logic        acc, wr, tick, arb_any, done_hit, sum_ok, fin_ok, fin_bad, timed_out;
  logic [4:0]  widx;
  state_e      state_q, state_d;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0]};

  assign acc  = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr   = acc & wb_we_i;
  assign widx = wb_adr_i[6:2];

  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

  wb_serial_rr_arb #(.NCH(NCH)) u_arb (
    .pending (pend_q),
    .last_ch (last_ch_q),
    .next_ch (arb_next),
    .any     (arb_any)
  );

  always_comb begin
    cur_mask = '0;
    raw_sel  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cur_ch_q == 3'(c)) begin
        cur_mask[c] = 1'b1;
        raw_sel     = raw_i[c*40 +: 40];
      end
    end
  end

  assign done_hit = |(done_i & cur_mask);
  assign sum_ok   = (dht_sum(raw_q[39:8]) == raw_q[7:0]);
  assign tick     = auto_en_q && (period_q != '0) && (tick_cnt_q == period_q - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (arb_any) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (done_hit)               state_d = StCheck;
        else if (tmo_q <= 32'd1)    state_d = StIdle;
      end
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    meas_o    = '0;
    fin_ok    = 1'b0;
    fin_bad   = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StStart: meas_o = cur_mask;
      StWait:  timed_out = ~done_hit & (tmo_q <= 32'd1);
      StCheck: begin
        fin_ok  = sum_ok;
        fin_bad = ~sum_ok;
      end
      default: ;
    endcase
  end

  always_comb begin
    pend_set  = (wr && widx == AdrTrig) ? wb_dat_i[NCH-1:0] : '0;
    pend_set |= tick ? chan_en_q[NCH-1:0] : '0;
    pend_clr  = (fin_ok | fin_bad | timed_out) ? cur_mask : '0;
    done_w1c  = (wr && widx == AdrDone)  ? wb_dat_i[NCH-1:0] : '0;
    ckerr_w1c = (wr && widx == AdrCkerr) ? wb_dat_i[NCH-1:0] : '0;
    toerr_w1c = (wr && widx == AdrToerr) ? wb_dat_i[NCH-1:0] : '0;
  end

  always_comb begin
    rd_data = '0;
    rd_ch   = widx[3:1];
    if (widx[4]) begin
      if (int'(rd_ch) < NCH) begin
        rd_data = widx[0] ? {16'h0, sum_q[rd_ch], cnt_q[rd_ch]} : data0_q[rd_ch];
      end
    end else begin
      case (widx)
        AdrCtrl:   rd_data = {16'h0, chan_en_q, 6'h0, irq_en_q, auto_en_q};
        AdrStatus: rd_data = {16'h0, 8'(pend_q), 1'b0, cur_ch_q, 3'b0, state_q != StIdle};
        AdrPeriod: rd_data = period_q;
        AdrDone:   rd_data = 32'(done_q);
        AdrCkerr:  rd_data = 32'(ckerr_q);
        AdrToerr:  rd_data = 32'(toerr_q);
        default:   rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
      auto_en_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      chan_en_q  <= '0;
      period_q   <= PERIOD_RST;
      tick_cnt_q <= '0;
      pend_q     <= '0;
      done_q     <= '0;
      ckerr_q    <= '0;
      toerr_q    <= '0;
      cur_ch_q   <= '0;
      // Start just before channel 0 so the first round visits channels in ascending order.
      last_ch_q  <= 3'(NCH - 1);
      tmo_q      <= '0;
      raw_q      <= '0;
      for (int c = 0; c < MaxCh; c++) begin
        data0_q[c] <= '0;
        sum_q[c]   <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= rd_data;
      irq_q <= irq_en_q & |(done_q | ckerr_q | toerr_q);

      if (wr && widx == AdrCtrl) begin
        auto_en_q <= wb_dat_i[CtrlAutoEn];
        irq_en_q  <= wb_dat_i[CtrlIrqEn];
        chan_en_q <= wb_dat_i[CtrlChanLsb +: 8];
      end
      if (wr && widx == AdrPeriod) period_q <= wb_dat_i;

      if ((wr && widx == AdrPeriod) || !auto_en_q || period_q == '0 || tick) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + 32'd1;
      end

      pend_q  <= (pend_q & ~pend_clr) | pend_set;
      done_q  <= (done_q & ~done_w1c) | (fin_ok ? cur_mask : '0);
      ckerr_q <= (ckerr_q & ~ckerr_w1c) | (fin_bad ? cur_mask : '0);
      toerr_q <= (toerr_q & ~toerr_w1c) | (timed_out ? cur_mask : '0);

      if (state_q == StIdle && arb_any) cur_ch_q <= arb_next;
      if (state_q == StStart)      tmo_q <= 32'(TIMEOUT);
      else if (state_q == StWait)  tmo_q <= tmo_q - 32'd1;
      if (state_q == StWait && done_hit) raw_q <= raw_sel;

      if (fin_ok) begin
        data0_q[cur_ch_q] <= raw_q[39:8];
        sum_q[cur_ch_q]   <= raw_q[7:0];
        cnt_q[cur_ch_q]   <= cnt_q[cur_ch_q] + 8'd1;
      end
      if (fin_ok || fin_bad || timed_out) last_ch_q <= cur_ch_q;
    end
  end

endmodule
